seven_bit_vector_reverse: RTL and testbench
===========================================

// Module: seven_bit_vector_reverse
// PURPOSE
//  Registered vector-reversal stage for datapath bit-order conversion (LSB-first <-> MSB-first).
//  Default mode mirrors an 8-bit word: out[i] = in[WIDTH-1-i].
//  Optional group modes reverse the order of 2/4-bit groups, keeping bit order inside each group.
//  Sits between serial/parallel front-ends and downstream logic that expects the opposite bit order.
// PARAMETERS
//  WIDTH      8   data width in bits; must be >= 2 and a multiple of 4
//  REGISTERED 1   1: output registered, 1-cycle latency; 0: combinational passthrough of reversal
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      in_vector qualifier
//  in_vector   in   WIDTH  input word
//  mode        in   2      00 bit reverse, 01 2-bit-group reverse, 10 4-bit-group reverse, 11 identity
//  out_valid   out  1      out_vector qualifier
//  out_vector  out  WIDTH  reversed word
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - Reset: at a rising clk edge with rst=1, out_vector <= 0 and out_valid <= 0. rst has priority over in_valid.
//  - Mode 00: out[i] = in[WIDTH-1-i] for all i.
//    Example: 8'b0010_0100 -> 8'b0010_0100; 8'b1000_0001 -> 8'b1000_0001; 8'b0000_0001 -> 8'b1000_0000.
//  - Mode 01: with g = WIDTH/2 groups, out[2k+1:2k] = in[2(g-1-k)+1 : 2(g-1-k)].
//  - Mode 10: with g = WIDTH/4 groups, out[4k+3:4k] = in[4(g-1-k)+3 : 4(g-1-k)].
//  - Mode 11: out = in.
//  - REGISTERED=1:
//    - At each rising edge with rst=0: out_valid <= in_valid.
//    - If in_valid=1, out_vector <= f(in_vector, mode).
//    - If in_valid=0, out_vector holds its previous value.
//    - Latency is exactly 1 cycle; a new word is accepted every cycle (no backpressure, no stall).
//  - REGISTERED=0:
//    - out_vector = f(in_vector, mode) combinationally; out_valid = in_valid.
//    - clk and rst are unused.
//  - mode is sampled with in_vector in the same cycle. Changing mode between words does not corrupt words already issued.
//  - Reversal is an involution: applying the same mode twice restores the original word.
//  - No X propagation from unused groups; every output bit maps to exactly one input bit.
//  - Reset asserted mid-stream: the word in the output register is discarded. out_valid=0 on the cycle after the rst edge.
//  - Back-to-back in_valid=1 for N cycles yields out_valid=1 for N consecutive cycles, delayed by one.
// TESTING
//  1. rst=1 for 2 cycles with in_valid=1, in=8'hFF -> out_vector=8'h00, out_valid=0 throughout.
//  2. Mode 00, in_valid=1, in=8'b0000_0001 -> next cycle out=8'b1000_0000, out_valid=1;
//     in=8'b1101_0010 -> out=8'b0100_1011.
//  3. Six random words back-to-back, mode 00 -> each out equals the bit mirror of the word from the previous cycle.
//     Palindromes (8'h81, 8'h24, 8'hA5) map to themselves.
//  4. Mode 01, in=8'b11_10_01_00 -> out=8'b00_01_10_11.
//     Mode 10, in=8'hA5 -> out=8'h5A.
//     Mode 11, in=8'h3C -> out=8'h3C.
//  5. in_valid=0 after word 8'h01 -> out_vector holds 8'h80 and out_valid=0.
//     Assert rst mid-stream -> out_vector=0 the following cycle.
//  6. Apply out_vector back as input with the same mode -> the original word is restored for all 256 values in every mode.

Source files
------------

// File: rtl/seven_bit_vector_reverse.sv
// seven_bit_vector_reverse
// Bit-order conversion stage. Mirrors a word bit-by-bit, or reverses the
// order of 2-bit or 4-bit groups while keeping bit order inside each group,
// or passes the word through unchanged. The result is either registered
// with one cycle of latency or presented combinationally.
module seven_bit_vector_reverse #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_vector,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_vector
);

    localparam int unsigned GROUPS2 = WIDTH / 2;
    localparam int unsigned GROUPS4 = WIDTH / 4;

    localparam logic [1:0] MODE_BIT   = 2'b00;
    localparam logic [1:0] MODE_PAIR  = 2'b01;
    localparam logic [1:0] MODE_NIBB  = 2'b10;

    // Pure permutation: every output bit is driven by exactly one input bit,
    // so no output bit can be left undriven in any mode.
    function automatic logic [WIDTH-1:0] reorder(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            MODE_BIT: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    r[i] = v[WIDTH-1-i];
                end
            end
            MODE_PAIR: begin
                for (int unsigned k = 0; k < GROUPS2; k++) begin
                    r[2*k +: 2] = v[2*(GROUPS2-1-k) +: 2];
                end
            end
            MODE_NIBB: begin
                for (int unsigned k = 0; k < GROUPS4; k++) begin
                    r[4*k +: 4] = v[4*(GROUPS4-1-k) +: 4];
                end
            end
            default: r = v;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] reordered;

    // Reordering network, shared by both output styles
    always_comb begin
        reordered = reorder(in_vector, mode);
    end

    generate
        if (REGISTERED) begin : g_reg
            // Output register: reset clears, valid words load, idle cycles hold
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid  <= 1'b0;
                    out_vector <= '0;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        out_vector <= reordered;
                    end
                end
            end
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            // Combinational passthrough of the reordered word
            always_comb begin
                out_valid  = in_valid;
                out_vector = reordered;
            end
        end
    endgenerate

endmodule

// File: tb/tb_seven_bit_vector_reverse.sv
// tb_seven_bit_vector_reverse
// Scoreboard bench: the driver pushes one expected {valid, vector} entry per
// issued cycle; a monitor on the falling edge pops and compares.
module tb_seven_bit_vector_reverse;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vector;
    logic [1:0] mode;
    logic       out_valid;
    logic [7:0] out_vector;

    typedef struct {
        bit         v;
        logic [7:0] d;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    int         checks;
    int         passed;
    logic [7:0] last_out;
    logic [7:0] fb;
    logic [7:0] w;

    seven_bit_vector_reverse #(.WIDTH(8), .REGISTERED(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_vector  (in_vector),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_vector (out_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: split the word into groups of s bits and place group k at
    // position g-1-k. Identity is the degenerate case of one 8-bit group.
    function automatic logic [7:0] ref_f(input logic [7:0] x, input logic [1:0] m);
        int unsigned s;
        int unsigned g;
        int unsigned r;
        int unsigned xi;
        s  = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 8;
        g  = 8 / s;
        xi = int'(x);
        r  = 0;
        for (int unsigned k = 0; k < g; k++) begin
            r = r | (((xi >> (s * k)) & ((1 << s) - 1)) << (s * (g - 1 - k)));
        end
        return r[7:0];
    endfunction

    // One cycle of stimulus with an explicitly stated expected vector
    task automatic drive_exp(input logic r, input logic v, input logic [7:0] x,
                             input logic [1:0] m, input logic [7:0] exp_vec);
        exp_t ent;
        rst       = r;
        in_valid  = v;
        in_vector = x;
        mode      = m;
        if (r) begin
            last_out = 8'h00;
            ent.v    = 1'b0;
        end else if (v) begin
            last_out = exp_vec;
            ent.v    = 1'b1;
        end else begin
            ent.v    = 1'b0;
        end
        ent.d = last_out;
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] x,
                         input logic [1:0] m);
        drive_exp(r, v, x, m, ref_f(x, m));
    endtask

    // Monitor: one expected entry per issued cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (out_valid !== e.v || out_vector !== e.d) begin
                $display("FAIL out t=%0t: out_valid=%0b out_vector=%h, expected valid=%0b vector=%h",
                         $time, out_valid, out_vector, e.v, e.d);
            end else begin
                passed++;
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        passed    = 0;
        last_out  = 8'h00;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vector = 8'h00;
        mode      = 2'b00;
        #1;

        // Reset dominates a valid input
        drive_exp(1'b1, 1'b1, 8'hFF, 2'b00, 8'h00);
        drive_exp(1'b1, 1'b1, 8'hFF, 2'b00, 8'h00);

        // Directed mode 00 examples with literal expectations
        drive_exp(1'b0, 1'b1, 8'b0000_0001, 2'b00, 8'b1000_0000);
        drive_exp(1'b0, 1'b1, 8'b1101_0010, 2'b00, 8'b0100_1011);
        drive_exp(1'b0, 1'b1, 8'h81, 2'b00, 8'h81);
        drive_exp(1'b0, 1'b1, 8'h24, 2'b00, 8'h24);
        drive_exp(1'b0, 1'b1, 8'hA5, 2'b00, 8'hA5);

        // Six random words back-to-back in mode 00
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 2'b00);
        end

        // Group modes and identity
        drive_exp(1'b0, 1'b1, 8'b11_10_01_00, 2'b01, 8'b00_01_10_11);
        drive_exp(1'b0, 1'b1, 8'hA5, 2'b10, 8'h5A);
        drive_exp(1'b0, 1'b1, 8'h3C, 2'b11, 8'h3C);

        // Hold while idle, then mid-stream reset
        drive_exp(1'b0, 1'b1, 8'h01, 2'b00, 8'h80);
        drive(1'b0, 1'b0, 8'h55, 2'b01);
        drive(1'b0, 1'b0, 8'h77, 2'b10);
        drive(1'b0, 1'b1, 8'hC3, 2'b10);
        drive(1'b1, 1'b1, 8'h0F, 2'b00);
        drive(1'b0, 1'b0, 8'h0F, 2'b00);
        drive(1'b0, 1'b1, 8'h0F, 2'b00);

        // Random stream: mode, valid and reset vary word to word
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        end

        // Involution: feed the DUT's own output back with the same mode and
        // expect the original word, for every value in every mode
        for (int m = 0; m < 4; m++) begin
            for (int x = 0; x < 256; x++) begin
                w = 8'(x);
                drive(1'b0, 1'b1, w, 2'(m));
                fb = out_vector;
                drive_exp(1'b0, 1'b1, fb, 2'(m), w);
            end
        end

        drive(1'b0, 1'b0, 8'h00, 2'b00);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb_q.size());
        end else begin
            passed++;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
